// File: rtl/fp_align_add_pkg.sv
// Shared floating-point datapath widths for the align/add block and the
// downstream normaliser / exponent generator.
package fp_align_add_pkg;

    localparam int EXP_W = 4;
    localparam int MAN_W = 7;
    localparam int SIG_W = MAN_W + 1;  // hidden 1 restored
    localparam int SUM_W = SIG_W + 1;  // carry out of the aligned add

endpackage

// File: rtl/fp_align_add_shifter.sv
// Saturating logical right shift: any shift amount of at least the data
// width yields zero, and shifted-out bits are simply dropped.
module align_shifter #(
    parameter int DATA_W = 8,
    parameter int AMT_W  = 4
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [AMT_W-1:0]  amt_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = '0;
        if (32'(amt_i) < DATA_W) begin
            data_o = data_i >> amt_i;
        end
    end

endmodule

// File: rtl/fp_align_add.sv
// Two-stage exponent compare / significand align / add with valid-ready
// flow control. Stage 1 picks the larger operand, stage 2 shifts and adds.
module fp_align_add
    import fp_align_add_pkg::*;
#(
    parameter int EXP_W = fp_align_add_pkg::EXP_W,
    parameter int MAN_W = fp_align_add_pkg::MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] Xe,
    input  logic [EXP_W-1:0] Ye,
    input  logic [MAN_W-1:0] Xm,
    input  logic [MAN_W-1:0] Ym,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             XeLTYe,
    output logic [EXP_W-1:0] XeOut,
    output logic [EXP_W-1:0] YeOut,
    output logic [MAN_W+1:0] sum
);

    localparam int SW = MAN_W + 1;

    logic [2:1]       vld_pipe_q;
    logic             s1_load, s2_load;

    // stage-1 combinational compare / select
    logic [SW-1:0]    xs, ys, lsig_d, ssig_d;
    logic [EXP_W-1:0] d_d;
    logic             lt_d;

    logic             lt1_q;
    logic [EXP_W-1:0] d1_q, xe1_q, ye1_q;
    logic [SW-1:0]    lsig1_q, ssig1_q;

    logic [SW-1:0]    ssig_sh;
    logic [SW:0]      sum_d;

    logic             lt2_q;
    logic [EXP_W-1:0] xe2_q, ye2_q;
    logic [SW:0]      sum_q;

    // Ready chain: a stage may load when empty or when its contents move on.
    assign s2_load  = !vld_pipe_q[2] || out_ready;
    assign s1_load  = !vld_pipe_q[1] || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        xs     = {1'b1, Xm};
        ys     = {1'b1, Ym};
        lt_d   = Xe < Ye;
        d_d    = lt_d ? (Ye - Xe) : (Xe - Ye);
        lsig_d = lt_d ? ys : xs;
        ssig_d = lt_d ? xs : ys;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q[1] <= 1'b0;
            lt1_q         <= 1'b0;
            d1_q          <= '0;
            xe1_q         <= '0;
            ye1_q         <= '0;
            lsig1_q       <= '0;
            ssig1_q       <= '0;
        end else if (s1_load) begin
            vld_pipe_q[1] <= in_valid;
            if (in_valid) begin
                lt1_q   <= lt_d;
                d1_q    <= d_d;
                xe1_q   <= Xe;
                ye1_q   <= Ye;
                lsig1_q <= lsig_d;
                ssig1_q <= ssig_d;
            end
        end
    end

    align_shifter #(
        .DATA_W (SW),
        .AMT_W  (EXP_W)
    ) u_shift (
        .data_i (ssig1_q),
        .amt_i  (d1_q),
        .data_o (ssig_sh)
    );

    assign sum_d = {1'b0, lsig1_q} + {1'b0, ssig_sh};

    // Output payload only changes on a real handoff, so it stays frozen
    // while downstream back-pressures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q[2] <= 1'b0;
            lt2_q         <= 1'b0;
            xe2_q         <= '0;
            ye2_q         <= '0;
            sum_q         <= '0;
        end else if (s2_load) begin
            vld_pipe_q[2] <= vld_pipe_q[1];
            if (vld_pipe_q[1]) begin
                lt2_q <= lt1_q;
                xe2_q <= xe1_q;
                ye2_q <= ye1_q;
                sum_q <= sum_d;
            end
        end
    end

    assign out_valid = vld_pipe_q[2];
    assign XeLTYe    = lt2_q;
    assign XeOut     = xe2_q;
    assign YeOut     = ye2_q;
    assign sum       = sum_q;

endmodule

// File: tb/tb_fp_align_add.sv
// Directed-vector bench for fp_align_add: latency, alignment corner cases,
// back-pressure streaming and mid-flight reset.
module tb_fp_align_add;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, XeLTYe;
    logic [3:0] Xe, Ye, XeOut, YeOut;
    logic [6:0] Xm, Ym;
    logic [8:0] sum;

    int nvec = 0;
    int nerr = 0;

    fp_align_add #(.EXP_W(4), .MAN_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Xe        (Xe),
        .Ye        (Ye),
        .Xm        (Xm),
        .Ym        (Ym),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .XeLTYe    (XeLTYe),
        .XeOut     (XeOut),
        .YeOut     (YeOut),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] xe, input logic [6:0] xm,
                         input logic [3:0] ye, input logic [6:0] ym);
        in_valid = v;
        Xe = xe; Xm = xm; Ye = ye; Ym = ym;
    endtask

    // One isolated transaction: accept, check nothing after one edge,
    // result after two edges, then drained.
    task automatic run_vec(input string tag, input logic [3:0] xe, input logic [6:0] xm,
                           input logic [3:0] ye, input logic [6:0] ym,
                           input logic [8:0] esum, input logic elt);
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, xe, xm, ye, ym);
        #1 chk({tag, "_inrdy"}, in_ready, 1);
        @(negedge clk);
        drive(1'b0, 4'hF, 7'h7F, 4'h0, 7'h00);
        #1 chk({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        #1;
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_sum"}, sum, esum);
        chk({tag, "_lt"}, XeLTYe, elt);
        chk({tag, "_xe"}, XeOut, xe);
        chk({tag, "_ye"}, YeOut, ye);
        @(negedge clk);
        #1 chk({tag, "_drain"}, out_valid, 0);
    endtask

    typedef struct {
        logic [3:0] xe, ye;
        logic [6:0] xm, ym;
        logic [8:0] esum;
        logic       elt;
    } vec_t;

    vec_t strm[4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, rcv, lowcnt;

        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 4'h0, 7'h00, 4'h0, 7'h00);
        #12;
        chk("rst_ovld", out_valid, 0);
        chk("rst_irdy", in_ready, 1);
        chk("rst_sum", sum, 0);
        chk("rst_lt", XeLTYe, 0);
        chk("rst_xe", XeOut, 0);
        chk("rst_ye", YeOut, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("eq",    4'd5,  7'h00, 4'd5, 7'h00, 9'h100, 1'b0);
        run_vec("d2",    4'd3,  7'h40, 4'd5, 7'h00, 9'h0B0, 1'b1);
        run_vec("d13",   4'd15, 7'h7F, 4'd2, 7'h00, 9'h0FF, 1'b0);
        run_vec("d7",    4'd0,  7'h00, 4'd7, 7'h00, 9'h081, 1'b1);
        run_vec("d8",    4'd8,  7'h00, 4'd0, 7'h7F, 9'h080, 1'b0);
        run_vec("max",   4'd9,  7'h7F, 4'd9, 7'h7F, 9'h1FE, 1'b0);

        // Streaming with back-pressure on cycles 3..5.
        strm[0] = '{xe:4'd4, xm:7'h00, ye:4'd4, ym:7'h00, esum:9'h100, elt:1'b0};
        strm[1] = '{xe:4'd1, xm:7'h00, ye:4'd3, ym:7'h20, esum:9'h0C0, elt:1'b1};
        strm[2] = '{xe:4'd6, xm:7'h7F, ye:4'd5, ym:7'h7F, esum:9'h17E, elt:1'b0};
        strm[3] = '{xe:4'd2, xm:7'h10, ye:4'd2, ym:7'h08, esum:9'h118, elt:1'b0};
        sent = 0; rcv = 0; lowcnt = 0;
        for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (sent < 4)
                drive(1'b1, strm[sent].xe, strm[sent].xm, strm[sent].ye, strm[sent].ym);
            else
                drive(1'b0, 4'hF, 7'h55, 4'h1, 7'h2A);
            #1;
            if (out_valid) begin
                if (rcv < 4) begin
                    chk("strm_sum", sum, strm[rcv].esum);
                    chk("strm_lt", XeLTYe, strm[rcv].elt);
                    chk("strm_xe", XeOut, strm[rcv].xe);
                    chk("strm_ye", YeOut, strm[rcv].ye);
                end else begin
                    chk("strm_extra", out_valid, 0);
                end
                if (out_ready) rcv++;
            end
            if (in_valid && in_ready) sent++;
            if (!in_ready) lowcnt++;
        end
        chk("strm_count", rcv, 4);
        chk("strm_stall", (lowcnt != 0), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, 4'h3, 7'h11, 4'h3, 7'h22);
            #1 chk("strm_nodup", out_valid, 0);
        end

        // Fill both stages, then reset mid-flight.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 4'd7, 7'h01, 4'd1, 7'h02);
        @(negedge clk);
        drive(1'b1, 4'd2, 7'h03, 4'd6, 7'h04);
        @(negedge clk);
        drive(1'b0, 4'd0, 7'h00, 4'd0, 7'h00);
        #1;
        chk("full_ovld", out_valid, 1);
        chk("full_irdy", in_ready, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_ovld", out_valid, 0);
        chk("mrst_irdy", in_ready, 1);
        chk("mrst_sum", sum, 0);
        chk("mrst_xe", XeOut, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("mrst_stale", out_valid, 0);
        end

        run_vec("post", 4'd1, 7'h00, 4'd0, 7'h00, 9'h0C0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
